// File: rtl/hazard_control_unit_mc.sv
// Hazard control for a five-stage pipeline: operand forwarding, load-use bubbles,
// stalls for multi-cycle execute ops, mispredict flushes and saturating event counters.
package hazard_control_unit_mc_pkg;
   localparam logic [1:0] FWD_NONE   = 2'b00;
   localparam logic [1:0] FWD_WB     = 2'b01;
   localparam logic [1:0] FWD_MEM    = 2'b10;
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;
endpackage

// state   | meaning
// LU_IDLE | no load-use bubble pending; a new hazard stalls this cycle
// LU_HOLD | extra load-use bubbles still owed, lu_cnt counts them down
// MD_IDLE | no multi-cycle op in flight; MD_Op_E starts one (stalls at once)
// MD_RUN  | op still busy in E, md_cnt counts the remaining stall cycles
// MD_DONE | op finishes and leaves E this cycle; MD_Op_E ignored
module hazard_control_unit_mc
   import hazard_control_unit_mc_pkg::*;
#(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_STALLS = 1,
   parameter int MD_LATENCY      = 4,
   parameter int CNT_W           = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [REG_ADDR_W-1:0] RS1_D,
   input  logic [REG_ADDR_W-1:0] RS2_D,
   input  logic [REG_ADDR_W-1:0] RS1_E,
   input  logic [REG_ADDR_W-1:0] RS2_E,
   input  logic [REG_ADDR_W-1:0] RD_E,
   input  logic [REG_ADDR_W-1:0] RD_M,
   input  logic [REG_ADDR_W-1:0] RD_W,
   input  logic [1:0]            Result_Src_Sel_E,
   input  logic                  REG_W_En_M,
   input  logic                  REG_W_En_W,
   input  logic                  Branch_Taken_E,
   input  logic                  Predict_Taken_E,
   input  logic                  MD_Op_E,
   input  logic                  Cnt_Clr,
   output logic [1:0]            FWD_SrcA,
   output logic [1:0]            FWD_SrcB,
   output logic                  Stall_En,
   output logic                  Stall_E,
   output logic                  Flush_D,
   output logic                  Flush_E,
   output logic                  Flush_M,
   output logic                  PC_En,
   output logic                  MD_Busy,
   output logic [CNT_W-1:0]      Stall_Count,
   output logic [CNT_W-1:0]      Flush_Count
);
   localparam int LUW = $clog2(LOAD_USE_STALLS + 1);
   localparam int MDW = $clog2(MD_LATENCY + 1);
   localparam logic [LUW-1:0] LU_LOAD = LUW'(LOAD_USE_STALLS - 1);
   localparam logic [MDW-1:0] MD_LOAD = (MD_LATENCY > 2) ? MDW'(MD_LATENCY - 2) : '0;

   typedef enum logic {LU_IDLE, LU_HOLD} lu_state_t;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

   lu_state_t      lu_q, lu_d;
   md_state_t      md_q, md_d;
   logic [LUW-1:0] lu_cnt_q, lu_cnt_d;
   logic [MDW-1:0] md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic mp, lu, md_start, md_stall, lu_stall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lu_q        <= LU_IDLE;
         md_q        <= MD_IDLE;
         lu_cnt_q    <= '0;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         lu_q        <= lu_d;
         md_q        <= md_d;
         lu_cnt_q    <= lu_cnt_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      mp       = Branch_Taken_E ^ Predict_Taken_E;
      lu       = (Result_Src_Sel_E == RESULT_MEM) && (RD_E != '0) &&
                 ((RD_E == RS1_D) || (RD_E == RS2_D));
      md_start = (md_q == MD_IDLE) && MD_Op_E && (MD_LATENCY > 1);
      md_stall = md_start || (md_q == MD_RUN);
      lu_stall = !md_stall && ((lu_q == LU_HOLD) || lu);

      md_d     = md_q;
      md_cnt_d = md_cnt_q;
      case (md_q)
         MD_IDLE: if (md_start) begin
            md_cnt_d = MD_LOAD;
            md_d     = (MD_LATENCY > 2) ? MD_RUN : MD_DONE;
         end
         MD_RUN: begin
            md_cnt_d = md_cnt_q - MDW'(1);
            if (md_cnt_q == MDW'(1)) md_d = MD_DONE;
         end
         default: md_d = MD_IDLE;
      endcase

      // a multi-cycle stall freezes the bubble sequence so no bubble is lost
      lu_d     = lu_q;
      lu_cnt_d = lu_cnt_q;
      if (!md_stall) begin
         case (lu_q)
            LU_IDLE: if (lu && (LOAD_USE_STALLS > 1)) begin
               lu_cnt_d = LU_LOAD;
               lu_d     = LU_HOLD;
            end
            default: begin
               lu_cnt_d = lu_cnt_q - LUW'(1);
               if (lu_cnt_q == LUW'(1)) lu_d = LU_IDLE;
            end
         endcase
      end

      if (mp) begin
         md_d     = MD_IDLE;
         md_cnt_d = '0;
         lu_d     = LU_IDLE;
         lu_cnt_d = '0;
      end
   end

   always_comb begin
      FWD_SrcA = FWD_NONE;
      FWD_SrcB = FWD_NONE;
      Stall_En = 1'b0;
      Stall_E  = 1'b0;
      Flush_D  = 1'b0;
      Flush_E  = 1'b0;
      Flush_M  = 1'b0;
      PC_En    = 1'b1;
      if (!RST) begin
         if (REG_W_En_M && (RD_M == RS1_E) && (RS1_E != '0))      FWD_SrcA = FWD_MEM;
         else if (REG_W_En_W && (RD_W == RS1_E) && (RS1_E != '0)) FWD_SrcA = FWD_WB;
         if (REG_W_En_M && (RD_M == RS2_E) && (RS2_E != '0))      FWD_SrcB = FWD_MEM;
         else if (REG_W_En_W && (RD_W == RS2_E) && (RS2_E != '0)) FWD_SrcB = FWD_WB;
         if (mp) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
         end else if (md_stall) begin
            Stall_En = 1'b1;
            Stall_E  = 1'b1;
            Flush_M  = 1'b1;
            PC_En    = 1'b0;
         end else if (lu_stall) begin
            Stall_En = 1'b1;
            Flush_E  = 1'b1;
            PC_En    = 1'b0;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Cnt_Clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!PC_En && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (mp && !(&flush_cnt_q))     flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   assign MD_Busy     = (md_q != MD_IDLE);
   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit_mc.sv
// Bench for hazard_control_unit_mc: two parameterisations driven in parallel and
// compared every cycle against a bubble-counting reference model.
module tb_hazard_control_unit_mc;
   import hazard_control_unit_mc_pkg::*;

   localparam int LUS_P[2] = '{3, 1};
   localparam int LAT_P[2] = '{4, 1};
   localparam int CMAX     = 15;

   logic       CLK, RST;
   logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
   logic [1:0] Result_Src_Sel_E;
   logic       REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E, MD_Op_E, Cnt_Clr;

   logic [1:0] fwa[2], fwb[2];
   logic       sen[2], se[2], fd[2], fe[2], fm[2], pce[2], busy[2];
   logic [3:0] scnt[2], fcnt[2];

   int n_checks = 0;
   int n_fail   = 0;
   int lu_left[2], md_run[2], m_sc[2], m_fc[2];
   bit md_done[2];

   hazard_control_unit_mc #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .MD_LATENCY(4), .CNT_W(4)) dut_a (
      .CLK(CLK), .RST(RST), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Result_Src_Sel_E(Result_Src_Sel_E),
      .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W), .Branch_Taken_E(Branch_Taken_E),
      .Predict_Taken_E(Predict_Taken_E), .MD_Op_E(MD_Op_E), .Cnt_Clr(Cnt_Clr),
      .FWD_SrcA(fwa[0]), .FWD_SrcB(fwb[0]), .Stall_En(sen[0]), .Stall_E(se[0]),
      .Flush_D(fd[0]), .Flush_E(fe[0]), .Flush_M(fm[0]), .PC_En(pce[0]), .MD_Busy(busy[0]),
      .Stall_Count(scnt[0]), .Flush_Count(fcnt[0]));

   hazard_control_unit_mc #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .MD_LATENCY(1), .CNT_W(4)) dut_b (
      .CLK(CLK), .RST(RST), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Result_Src_Sel_E(Result_Src_Sel_E),
      .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W), .Branch_Taken_E(Branch_Taken_E),
      .Predict_Taken_E(Predict_Taken_E), .MD_Op_E(MD_Op_E), .Cnt_Clr(Cnt_Clr),
      .FWD_SrcA(fwa[1]), .FWD_SrcB(fwb[1]), .Stall_En(sen[1]), .Stall_E(se[1]),
      .Flush_D(fd[1]), .Flush_E(fe[1]), .Flush_M(fm[1]), .PC_En(pce[1]), .MD_Busy(busy[1]),
      .Stall_Count(scnt[1]), .Flush_Count(fcnt[1]));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] s);
      if (s == 0) return FWD_NONE;
      if (REG_W_En_M && RD_M == s) return FWD_MEM;
      if (REG_W_En_W && RD_W == s) return FWD_WB;
      return FWD_NONE;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         lu_left[k] = 0; md_run[k] = 0; md_done[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
   endtask

   // check one cycle at the falling edge, then advance the model across the rising edge
   task automatic step();
      bit mp, lu;
      @(negedge CLK);
      mp = Branch_Taken_E ^ Predict_Taken_E;
      lu = (Result_Src_Sel_E == RESULT_MEM) && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
      for (int k = 0; k < 2; k++) begin
         bit mds, starting, lus;
         logic e_sen, e_se, e_fd, e_fe, e_fm, e_pc;
         starting = !RST && md_run[k] == 0 && !md_done[k] && MD_Op_E && LAT_P[k] > 1;
         mds      = !RST && (md_run[k] > 0 || starting);
         lus      = !RST && !mds && (lu_left[k] > 0 || lu);
         {e_sen, e_se, e_fd, e_fe, e_fm, e_pc} = 6'b000001;
         if (!RST && mp)  {e_sen, e_se, e_fd, e_fe, e_fm, e_pc} = 6'b001101;
         else if (mds)    {e_sen, e_se, e_fd, e_fe, e_fm, e_pc} = 6'b110010;
         else if (lus)    {e_sen, e_se, e_fd, e_fe, e_fm, e_pc} = 6'b100100;
         chk($sformatf("fwd_a[%0d]", k), 32'(fwa[k]), RST ? 32'(FWD_NONE) : 32'(fwd_ref(RS1_E)));
         chk($sformatf("fwd_b[%0d]", k), 32'(fwb[k]), RST ? 32'(FWD_NONE) : 32'(fwd_ref(RS2_E)));
         chk($sformatf("stall_en[%0d]", k), 32'(sen[k]), 32'(e_sen));
         chk($sformatf("stall_e[%0d]", k),  32'(se[k]),  32'(e_se));
         chk($sformatf("flush_d[%0d]", k),  32'(fd[k]),  32'(e_fd));
         chk($sformatf("flush_e[%0d]", k),  32'(fe[k]),  32'(e_fe));
         chk($sformatf("flush_m[%0d]", k),  32'(fm[k]),  32'(e_fm));
         chk($sformatf("pc_en[%0d]", k),    32'(pce[k]), 32'(e_pc));
         chk($sformatf("md_busy[%0d]", k),  32'(busy[k]), 32'(md_run[k] > 0 || md_done[k]));
         chk($sformatf("stall_cnt[%0d]", k), 32'(scnt[k]), 32'(m_sc[k]));
         chk($sformatf("flush_cnt[%0d]", k), 32'(fcnt[k]), 32'(m_fc[k]));
         if (RST) begin
            lu_left[k] = 0; md_run[k] = 0; md_done[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else begin
            if (Cnt_Clr) begin
               m_sc[k] = 0; m_fc[k] = 0;
            end else begin
               if (!e_pc && m_sc[k] < CMAX) m_sc[k]++;
               if (mp && m_fc[k] < CMAX)    m_fc[k]++;
            end
            if (mp) begin
               lu_left[k] = 0; md_run[k] = 0; md_done[k] = 0;
            end else begin
               if (!mds && lu_left[k] > 0) lu_left[k]--;
               else if (!mds && lu)        lu_left[k] = LUS_P[k] - 1;
               if (md_done[k]) md_done[k] = 0;
               else if (starting) begin
                  md_run[k]  = LAT_P[k] - 2;
                  md_done[k] = (md_run[k] == 0);
               end else if (md_run[k] > 0) begin
                  md_run[k]--;
                  md_done[k] = (md_run[k] == 0);
               end
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
      Result_Src_Sel_E = RESULT_ALU;
      {REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E, MD_Op_E, Cnt_Clr} = '0;
   endtask

   initial begin
      RST = 1'b1;
      idle_inputs();
      model_reset();
      MD_Op_E = 1'b1;
      Branch_Taken_E = 1'b1;
      #1;
      chk("rst_pc_en", 32'(pce[0]), 32'd1);
      chk("rst_stall_e", 32'(se[0]), 32'd0);
      step();
      step();
      idle_inputs();
      RST = 1'b0;
      step();

      REG_W_En_M = 1; REG_W_En_W = 1; RD_M = 5; RD_W = 5; RS1_E = 5;
      #1 chk("fwd_m_beats_w", 32'(fwa[0]), 32'(FWD_MEM));
      step();
      RD_M = 0; RS1_E = 0;
      #1 chk("fwd_x0", 32'(fwa[0]), 32'(FWD_NONE));
      step();
      RS1_E = 5;
      #1 chk("fwd_wb", 32'(fwa[0]), 32'(FWD_WB));
      step();
      idle_inputs();

      Cnt_Clr = 1; step(); Cnt_Clr = 0;
      Result_Src_Sel_E = RESULT_MEM; RD_E = 1; RS2_D = 1;
      #1 chk("lu_c1_stall", 32'({sen[0], fe[0], pce[0]}), 32'(3'b110));
      step();
      idle_inputs();
      #1 chk("lu_c2_stall", 32'({sen[0], fe[0], pce[0]}), 32'(3'b110));
      chk("lu1_released", 32'(pce[1]), 32'd1);
      step();
      #1 chk("lu_c3_stall", 32'({sen[0], fe[0], pce[0]}), 32'(3'b110));
      step();
      #1 chk("lu_after", 32'({sen[0], fe[0], pce[0]}), 32'(3'b001));
      chk("lu_stall_count", 32'(scnt[0]), 32'd3);
      step();

      MD_Op_E = 1;
      for (int c = 1; c <= 4; c++) begin
         #1 chk($sformatf("md_c%0d_stall", c), 32'({sen[0], se[0], fm[0]}), (c < 4) ? 32'(3'b111) : 32'd0);
         if (c == 1) chk("md_lat1_nostall", 32'(se[1]), 32'd0);
         if (c == 4) chk("md_c4_busy", 32'(busy[0]), 32'd1);
         step();
      end
      MD_Op_E = 0;
      #1 chk("md_c5_idle", 32'(busy[0]), 32'd0);
      step();

      Branch_Taken_E = 1; Result_Src_Sel_E = RESULT_MEM; RD_E = 2; RS1_D = 2;
      #1 chk("mp_flush", 32'({fd[0], fe[0], sen[0], pce[0]}), 32'(4'b1101));
      chk("mp_fc_before", 32'(fcnt[0]), 32'(m_fc[0]));
      step();
      idle_inputs();
      #1 chk("mp_fc_inc", 32'(fcnt[0]), 32'(m_fc[0]));
      step();

      MD_Op_E = 1;
      step();
      step();
      RST = 1;
      #1;
      chk("arst_busy", 32'(busy[0]), 32'd0);
      chk("arst_stall_e", 32'(se[0]), 32'd0);
      chk("arst_scnt", 32'(scnt[0]), 32'd0);
      model_reset();
      step();
      RST = 0; MD_Op_E = 0;
      #1 chk("post_rst_pc", 32'({pce[0], se[0], sen[0]}), 32'(3'b100));
      step();

      Cnt_Clr = 1; step(); Cnt_Clr = 0;
      Result_Src_Sel_E = RESULT_MEM; RD_E = 3; RS1_D = 3;
      for (int c = 0; c < 20; c++) step();
      chk("sat_scnt", 32'(scnt[0]), 32'd15);
      Cnt_Clr = 1;
      step();
      chk("clr_beats_inc", 32'(scnt[0]), 32'd0);
      idle_inputs();
      step();

      for (int c = 0; c < 1500; c++) begin
         RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
         RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
         RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
         RD_W  = 5'($urandom_range(0, 3));
         Result_Src_Sel_E = ($urandom_range(0, 1) == 1) ? RESULT_MEM : 2'($urandom_range(0, 3));
         REG_W_En_M = 1'($urandom_range(0, 1)); REG_W_En_W = 1'($urandom_range(0, 1));
         Branch_Taken_E = 1'($urandom_range(0, 1));
         Predict_Taken_E = ($urandom_range(0, 11) == 0) ? ~Branch_Taken_E : Branch_Taken_E;
         MD_Op_E = ($urandom_range(0, 3) == 0);
         Cnt_Clr = ($urandom_range(0, 63) == 0);
         RST = ($urandom_range(0, 199) == 0);
         if (RST) model_reset();
         step();
      end
      RST = 0;
      idle_inputs();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_control_unit_mc.md
# hazard_control_unit_mc

Parametrised successor to the pipeline hazard control unit. It supports multi-cycle execute operations (M-extension divider/multiplier), a configurable load-use penalty for slower data memories, and saturating performance counters for stall and flush cycles. It sits beside the five-stage datapath. It takes register indices and control bits from the D/E/M/W stages and drives the forwarding muxes, pipeline-register enables and flushes, and the PC enable.

## Interface
- REG_ADDR_W, 5, register index width
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (legal 1..4)
- MD_LATENCY, 4, cycles a multi-cycle op occupies E (legal 1..64; 1 = single-cycle, no stall)
- CNT_W, 32, performance counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- RS1_D, RS2_D  in  REG_ADDR_W  D-stage source registers
- RS1_E, RS2_E, RD_E  in  REG_ADDR_W  E-stage sources and destination
- RD_M, RD_W  in  REG_ADDR_W  M/W destinations
- Result_Src_Sel_E  in  2  E result source; RESULT_MEM marks a load
- REG_W_En_M, REG_W_En_W  in  1  register write enables in M/W
- Branch_Taken_E, Predict_Taken_E  in  1  resolved vs predicted branch direction
- MD_Op_E  in  1  E holds a multi-cycle op; stays high while E is held
- Cnt_Clr  in  1  synchronous clear of both counters
- FWD_SrcA, FWD_SrcB  out  2  FWD_NONE / FWD_MEM / FWD_WB (definitions package)
- Stall_En  out  1  hold IF/ID register
- Stall_E  out  1  hold ID/EX register
- Flush_D, Flush_E, Flush_M  out  1  bubble into ID/EX-input, EX, MEM registers respectively
- PC_En  out  1  PC update enable
- MD_Busy  out  1  multi-cycle FSM not IDLE
- Stall_Count, Flush_Count  out  CNT_W  performance counters

## Operation
- Forwarding (combinational), per source S in {RS1_E, RS2_E}:
  - FWD_MEM if REG_W_En_M, RD_M==S and S!=0.
  - Else FWD_WB if REG_W_En_W, RD_W==S and S!=0.
  - Else FWD_NONE. M beats W.
- Mispredict: mp = Branch_Taken_E ^ Predict_Taken_E.
  - mp asserts Flush_D=1 and Flush_E=1 in the same cycle.
- Load-use detect: lu = (Result_Src_Sel_E==RESULT_MEM) && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D).
- Load-use FSM, states LU_IDLE / LU_HOLD, counter lu_cnt:
  - In LU_IDLE, lu asserts Stall_En=1, Flush_E=1, PC_En=0.
  - If LOAD_USE_STALLS>1, that cycle loads lu_cnt<=LOAD_USE_STALLS-1 and moves to LU_HOLD.
  - In LU_HOLD: same three outputs, regardless of lu; lu_cnt decrements; exit to LU_IDLE when lu_cnt==1.
  - Total bubbles = LOAD_USE_STALLS.
- Multi-cycle FSM, states MD_IDLE / MD_RUN / MD_DONE, counter md_cnt. Only active when MD_LATENCY>1.
  - MD_IDLE with MD_Op_E: assert md_stall this cycle; md_cnt<=MD_LATENCY-2; next state MD_RUN if MD_LATENCY>2, else MD_DONE.
  - MD_RUN: md_stall; md_cnt decrements; go to MD_DONE when md_cnt==1.
  - MD_DONE: no stall; MD_Op_E ignored, because the held op is leaving E; always return to MD_IDLE.
  - md_stall drives Stall_En=1, Stall_E=1, Flush_M=1, PC_En=0.
  - md_stall lasts exactly MD_LATENCY-1 cycles.
- Priority: mp > md_stall > load-use.
  - mp forces Stall_En=0, Stall_E=0 and PC_En=1.
  - mp returns both FSMs to IDLE at the next edge.
  - Load-use detection is ignored while md_stall is active.
- Default outputs: Stall_En=0, Stall_E=0, Flush_D=0, Flush_E=0, Flush_M=0, PC_En=1.
- Counters:
  - Stall_Count increments on every cycle with PC_En==0.
  - Flush_Count increments on every cycle with mp==1.
  - Both saturate at all-ones.
  - Cnt_Clr has priority over increment.

## Timing
- Reset (asynchronous, immediate): both FSMs IDLE, lu_cnt=0, md_cnt=0, counters=0, MD_Busy=0.
- While RST is high: Stall_En=0, Stall_E=0, all flushes=0, PC_En=1, FWD_SrcA=FWD_NONE, FWD_SrcB=FWD_NONE.
- Forwarding, mp flushes and the first stall cycle are combinational: zero latency in the cycle the condition appears.
- Counters reflect a cycle's events after the following rising edge.
- Reset mid-stall aborts the stall; the first cycle after reset release uses default outputs unless an input condition is present.
- Simultaneous Cnt_Clr and event: counter = 0.
- A counter at saturation stays at all-ones.

## Test plan
- Forwarding: REG_W_En_M=1, REG_W_En_W=1, RD_M=RD_W=RS1_E=5 -> FWD_SrcA=FWD_MEM. With RD_M=0, RS1_E=0 -> FWD_NONE.
- Load-use, LOAD_USE_STALLS=3: load in E with RD_E=1 and RS2_D=1 for one cycle -> exactly 3 consecutive cycles of Stall_En=1, Flush_E=1, PC_En=0, then defaults. Stall_Count=3.
- Multi-cycle op, MD_LATENCY=4: MD_Op_E held high for 4 cycles -> Stall_En=1, Stall_E=1, Flush_M=1 on cycles 1-3, released on cycle 4, MD_Busy low on cycle 5. MD_LATENCY=1 -> no stall.
- Mispredict: Branch_Taken_E=1, Predict_Taken_E=0 while the load-use condition is also true -> Flush_D=1, Flush_E=1, Stall_En=0, PC_En=1. Flush_Count increments by 1.
- Async reset: assert RST during MD_RUN -> MD_Busy=0 and Stall_E=0 immediately, counters=0. After release, MD_Op_E=0 -> defaults.
- Saturation and clear, CNT_W=4: 20 stall cycles -> Stall_Count=15. Pulse Cnt_Clr -> 0 on the next edge.
